// File: rtl/mod_updown_counter.sv
// ============================================================================
// Module   : mod_updown_counter
// Brief    : Synchronous modulo-N up/down counter with load, clear, wrap or
//            saturate boundary mode, cascade terminal count and sticky ovf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_updown_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    generate
        if ((WIDTH < 1) || (WIDTH > 32) || (MODULUS < 2) ||
            (MODULUS > (64'd1 << WIDTH))) begin : g_bad_params
            $error("mod_updown_counter: WIDTH/MODULUS out of legal range");
        end
    endgenerate

    // WIDTH-bit terminal value keeps MODULUS == 2**WIDTH representable.
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_ovf_set;
    logic             w_ovf_nxt;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_load_ok;

    assign w_at_top  = (r_q == c_MAX);
    assign w_at_bot  = (r_q == '0);
    assign w_load_ok = (64'(load_val) < MODULUS);

    assign tc  = en & (up ? w_at_top : w_at_bot);
    assign q   = r_q;
    assign ovf = r_ovf;

    always_comb begin
        w_q_nxt   = r_q;
        w_ovf_set = 1'b0;
        if (clr) begin
            w_q_nxt = '0;
        end else if (load) begin
            if (w_load_ok) begin
                w_q_nxt = load_val;
            end else begin
                w_q_nxt   = c_MAX;
                w_ovf_set = 1'b1;
            end
        end else if (en) begin
            w_ovf_set = tc;
            if (up) begin
                if (!w_at_top)     w_q_nxt = r_q + c_ONE;
                else if (!SATURATE) w_q_nxt = '0;
            end else begin
                if (!w_at_bot)     w_q_nxt = r_q - c_ONE;
                else if (!SATURATE) w_q_nxt = c_MAX;
            end
        end
    end

    // A set condition on the same edge as ovf_clr takes precedence.
    assign w_ovf_nxt = w_ovf_set | (r_ovf & ~ovf_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ============================================================================
// Module   : tb_mod_updown_counter
// Brief    : Randomised and directed checks of mod_updown_counter against an
//            arithmetic reference model (wrap, saturate, cascade, full range).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_updown_counter;

    localparam int c_N = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           clr = 1'b0;
    logic           en = 1'b0;
    logic           up = 1'b0;
    logic           load = 1'b0;
    logic [3:0]     load_val = '0;
    logic           ovf_clr = 1'b0;

    logic [c_N-1:0][3:0] qv;
    logic [c_N-1:0]      tcv;
    logic [c_N-1:0]      ovv;

    // 0: wrap mod 10, 1: saturate mod 10, 2/3: cascade mod 10, 4: wrap mod 16
    int mod_of [c_N] = '{10, 10, 10, 10, 16};
    bit sat_of [c_N] = '{0, 1, 0, 0, 0};
    int mq     [c_N];
    bit movf   [c_N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(qv[0]), .tc(tcv[0]), .ovf(ovv[0]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(qv[1]), .tc(tcv[1]), .ovf(ovv[1]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_casc0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(qv[2]), .tc(tcv[2]), .ovf(ovv[2]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_casc1 (
        .clk(clk), .rst(rst), .clr(clr), .en(tcv[2]), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(qv[3]), .tc(tcv[3]), .ovf(ovv[3]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(qv[4]), .tc(tcv[4]), .ovf(ovv[4]));

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_tc(input int qq, input int m, input bit e, input bit u);
        return e && (u ? (qq == m - 1) : (qq == 0));
    endfunction

    function automatic int ref_next(input int qq, input int m, input bit s,
                                    input bit e, input int lv);
        if (clr)  return 0;
        if (load) return (lv < m) ? lv : m - 1;
        if (!e)   return qq;
        if (up)   return s ? ((qq + 1 > m - 1) ? m - 1 : qq + 1) : (qq + 1) % m;
        return s ? ((qq - 1 < 0) ? 0 : qq - 1) : (qq + m - 1) % m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < c_N; k++) begin
            mq[k]   = 0;
            movf[k] = 1'b0;
        end
    endtask

    task automatic check_all_state(input string what);
        for (int k = 0; k < c_N; k++) begin
            check_eq($sformatf("%s q[%0d]", what, k), int'(qv[k]), mq[k]);
            check_eq($sformatf("%s ovf[%0d]", what, k), int'(ovv[k]), int'(movf[k]));
        end
    endtask

    // Inputs must already be applied; checks tc, advances one edge, checks q/ovf.
    task automatic step(input string what);
        int nq  [c_N];
        bit nov [c_N];
        bit e   [c_N];
        bit t   [c_N];
        bit setc;
        for (int k = 0; k < c_N; k++)
            e[k] = (k == 3) ? ref_tc(mq[2], mod_of[2], en, up) : en;
        #1;
        for (int k = 0; k < c_N; k++) begin
            t[k] = ref_tc(mq[k], mod_of[k], e[k], up);
            check_eq($sformatf("%s tc[%0d]", what, k), int'(tcv[k]), int'(t[k]));
            setc = !clr && ((load && int'(load_val) >= mod_of[k]) || (!load && t[k]));
            nq[k]  = ref_next(mq[k], mod_of[k], sat_of[k], e[k], int'(load_val));
            nov[k] = setc ? 1'b1 : (ovf_clr ? 1'b0 : movf[k]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < c_N; k++) begin
            mq[k]   = nq[k];
            movf[k] = nov[k];
        end
        check_all_state(what);
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit e,
                         input bit u, input bit oc);
        clr = c; load = l; load_val = 4'(lv); en = e; up = u; ovf_clr = oc;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        check_all_state("reset");
        for (int k = 0; k < c_N; k++)
            check_eq($sformatf("reset tc[%0d]", k), int'(tcv[k]), 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        pulse_reset();

        // Up-count wrap: 12 edges from 0
        drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) step("upwrap");
        check_eq("upwrap final q", int'(qv[0]), 2);
        check_eq("upwrap final ovf", int'(ovv[0]), 1);
        check_eq("upwrap sat holds q", int'(qv[1]), 9);

        // Clear ovf, load 2, count down 4 edges
        drive(0, 0, 0, 0, 1, 1); step("ovfclr");
        check_eq("ovfclr sat ovf", int'(ovv[1]), 0);
        drive(0, 1, 2, 0, 0, 0); step("load2");
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step("down");
        check_eq("down sat ovf before hold", int'(ovv[1]), 0);
        for (int i = 0; i < 2; i++) step("downhold");
        check_eq("downhold sat q", int'(qv[1]), 0);
        check_eq("downhold sat ovf", int'(ovv[1]), 1);
        check_eq("downwrap q", int'(qv[0]), 8);

        // Priority clr > load > en
        drive(0, 1, 7, 0, 1, 0); step("load7");
        drive(1, 1, 5, 1, 1, 0); step("prio clr");
        check_eq("prio clr q", int'(qv[0]), 0);
        drive(0, 1, 5, 1, 1, 0); step("prio load");
        check_eq("prio load q", int'(qv[0]), 5);

        // Illegal load, ovf_clr, ovf_clr colliding with a wrap
        drive(0, 0, 0, 0, 1, 1); step("clr ovf");
        drive(0, 1, 12, 0, 1, 0); step("illegal");
        check_eq("illegal q", int'(qv[0]), 9);
        check_eq("illegal ovf", int'(ovv[0]), 1);
        drive(0, 0, 0, 0, 1, 1); step("ovfclr en0");
        check_eq("ovfclr en0 ovf", int'(ovv[0]), 0);
        drive(0, 0, 0, 1, 1, 1); step("ovfclr vs wrap");
        check_eq("ovfclr vs wrap q", int'(qv[0]), 0);
        check_eq("ovfclr vs wrap ovf", int'(ovv[0]), 1);

        // Asynchronous reset between edges while q=6, en=1
        drive(0, 1, 5, 0, 1, 0); step("load5");
        drive(0, 0, 0, 1, 1, 0); step("to6");
        check_eq("pre-areset q", int'(qv[0]), 6);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("areset q", int'(qv[0]), 0);
        check_eq("areset ovf", int'(ovv[0]), 0);
        check_all_state("areset");
        #1 rst = 1'b0;
        step("after areset");
        check_eq("after areset q", int'(qv[0]), 1);

        // Cascade: 25 edges up from reset gives {2,5}
        pulse_reset();
        drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 25; i++) step("cascade");
        check_eq("cascade stage0", int'(qv[2]), 5);
        check_eq("cascade stage1", int'(qv[3]), 2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 7) == 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Synchronous, parametrised modulo-N up/down counter. It is the next generation of the 4-bit ripple counter.
- All state bits share one clock edge, so there is no ripple skew.
- Adds direction control, enable, parallel load, synchronous clear, wrap or saturate mode, a cascade-ready terminal-count output and a sticky overflow flag.
- Used as the general counter/timer primitive in the lab datapaths. Instances can be cascaded by tying one stage's tc to the next stage's en.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH. Elaboration fails if out of range.
- SATURATE, 0, boundary mode: 0 = wrap at the boundary, 1 = hold at the boundary.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to 0.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- ovf_clr  input  1  synchronous clear of ovf.
- q  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count.
- ovf  output  1  registered sticky overflow/error flag.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is high, q=0 and ovf=0. tc follows its equation and is therefore 0 whenever en=0.
- Priority at each rising clk edge (rst low): clr > load > en. At most one action takes effect per edge.
- clr=1: q <= 0. ovf is unchanged unless ovf_clr is also high.
- load=1 (clr=0), load_val < MODULUS: q <= load_val.
- load=1 (clr=0), load_val >= MODULUS: q <= MODULUS-1 and ovf <= 1 (illegal-load error).
- en=1, up=1 (clr=0, load=0):
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1: q <= 0 if SATURATE=0, else q holds.
- en=1, up=0 (clr=0, load=0):
  - q > 0: q <= q-1.
  - q == 0: q <= MODULUS-1 if SATURATE=0, else q holds.
- en=0 with no clr/load: q holds. Toggling up while en=0 has no effect on q.
- Latency: one clock from the control inputs to the new q. There are no pipeline stages.
- tc = en & ((up & q==MODULUS-1) | (~up & q==0)). This is combinational and has zero latency, for cascading.
  - tc is not gated by clr or load.
  - In a cascade, the downstream stage advances on the same edge the upstream stage wraps.
- ovf set conditions (registered):
  - a boundary event: en=1 with tc=1, while clr=0 and load=0, in either SATURATE mode;
  - or an illegal load, as above.
- ovf clearing:
  - ovf_clr=1 clears ovf on the next edge.
  - If ovf_clr and a set condition occur on the same edge, set wins and ovf=1.
- q never leaves 0..MODULUS-1 outside reset. There is no unreachable-state lockup even when MODULUS < 2^WIDTH.
- Reset mid-operation: asserting rst forces q=0 and ovf=0 immediately, independent of clk. Counting resumes on the first rising edge after rst deasserts, per the inputs then present.
- Arithmetic is unsigned, WIDTH bits. Comparisons against MODULUS-1 use a WIDTH-bit constant, so MODULUS = 2^WIDTH is legal.

Test Plan:
- Up-count wrap (WIDTH=4, MODULUS=10, SATURATE=0):
  - stimulus: rst pulse, then en=1, up=1 for 12 edges;
  - response: q goes 1..9, 0, 1, 2; tc=1 only while q=9; ovf=1 after the 9->0 edge.
- Down-count and saturate (MODULUS=10, SATURATE=1):
  - stimulus: load 2, then en=1, up=0 for 4 edges;
  - response: q goes 1, 0, 0, 0; tc=1 while q=0; ovf sets on the first held edge.
- Priority:
  - stimulus: one edge with clr=1, load=1 (load_val=5), en=1, q=7;
  - response: q=0.
  - stimulus: next edge with clr=0, load=1, en=1;
  - response: q=5, not 6.
- Illegal load and ovf_clr (MODULUS=10):
  - stimulus: load load_val=12;
  - response: q=9, ovf=1.
  - stimulus: ovf_clr=1 with en=0;
  - response: ovf=0.
  - stimulus: ovf_clr=1 on the same edge as a 9->0 wrap;
  - response: ovf stays 1.
- Asynchronous reset:
  - stimulus: assert rst between clock edges while q=6, en=1;
  - response: q=0 and ovf=0 before the next edge; q=1 on the first edge after release.
- Cascade:
  - stimulus: two instances (MODULUS=10), stage-1 en tied to stage-0 tc, 25 edges up;
  - response: {stage1, stage0} = {2, 5}; stage 1 increments on exactly the edges where stage 0 goes 9->0.
